// File: rtl/ccip_wr_completion_tracker.sv
// ccip_wr_completion_tracker
//   Watches the CCI-P c1 write path next to a write-issuing AFU stage. It counts
//   single-line write requests and (possibly packed) write responses, keeps an
//   outstanding-line count, gives the issuer a registered back-pressure hint,
//   pulses done once every expected line has been issued and acknowledged, and
//   latches a sticky error on underflow, over-issue or response timeout.
//
// Optional build macro: CCIP_WR_TRK_PERF_EN
//   When defined, run_cycles counts cycles spent in RUN/DRAIN for the last run.
//   When undefined, run_cycles is tied to zero and no counter exists.
//
// Ports:
//   clk              CCI-P primary clock (pClk)
//   reset            synchronous, active-high soft reset
//   start            arm pulse; honoured in IDLE, DONE or ERROR
//   expected_lines   lines to be written, sampled on an accepted start
//   wr_req_valid     one single-line c1 write request issued this cycle
//   wr_rsp_valid     c1 write response valid this cycle
//   wr_rsp_format    1 = packed response
//   wr_rsp_cl_num    packed response covers cl_num+1 lines
//   issue_ok         outstanding below MAX_OUTSTANDING and running
//   outstanding      lines issued but not yet acknowledged
//   req_count        lines issued since start (saturating)
//   rsp_count        lines acknowledged since start (saturating)
//   busy             RUN or DRAIN
//   done             one-cycle pulse on entry to DONE
//   error            sticky, high while in ERROR
//   err_code         0 none, 1 underflow, 2 over-issue, 3 timeout
//   run_cycles       RUN/DRAIN cycle count of the current/last run
module ccip_wr_completion_tracker #(
  parameter int MAX_OUTSTANDING = 64,
  parameter int CNT_W           = 16,
  parameter int TIMEOUT_CYCLES  = 4096
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic [CNT_W-1:0]                   expected_lines,
  input  logic                               wr_req_valid,
  input  logic                               wr_rsp_valid,
  input  logic                               wr_rsp_format,
  input  logic [1:0]                         wr_rsp_cl_num,
  output logic                               issue_ok,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
  output logic [CNT_W-1:0]                   req_count,
  output logic [CNT_W-1:0]                   rsp_count,
  output logic                               busy,
  output logic                               done,
  output logic                               error,
  output logic [1:0]                         err_code,
  output logic [31:0]                        run_cycles
);

  localparam int OW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [OW-1:0] OUT_MAX   = OW'(MAX_OUTSTANDING);
  localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_CYCLES);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_ERROR = 3'd4;

  logic [2:0]       state_reg, state_next;
  logic [OW-1:0]    outstanding_reg, outstanding_next;
  logic [CNT_W-1:0] req_count_reg, req_count_next;
  logic [CNT_W-1:0] rsp_count_reg, rsp_count_next;
  logic [CNT_W-1:0] expected_reg, expected_next;
  logic [1:0]       err_code_reg, err_code_next;
  logic [TW-1:0]    tmo_reg, tmo_next;
  logic             issue_ok_reg, busy_reg, done_reg, error_reg;

  logic [2:0]       rsp_lines;
  logic [2:0]       credit;
  logic [OW:0]      avail;
  logic [OW:0]      out_upd;
  logic [CNT_W:0]   rsp_sum;
  logic [TW-1:0]    tmo_inc;
  logic             active, start_ok, underflow, over_issue, timeout;

  always_comb begin
    rsp_lines = wr_rsp_format ? ({1'b0, wr_rsp_cl_num} + 3'd1) : 3'd1;
    credit    = wr_rsp_valid ? rsp_lines : 3'd0;
    // Lines available to be acknowledged this cycle: a same-cycle request counts.
    avail     = {1'b0, outstanding_reg} + (OW+1)'(wr_req_valid);
    out_upd   = avail - (OW+1)'(credit);
    rsp_sum   = {1'b0, rsp_count_reg} + (CNT_W+1)'(credit);
    active    = (state_reg == S_RUN) || (state_reg == S_DRAIN);
    start_ok  = start && !active;
    // Compare at 32 bits so a 4-line credit is never truncated for tiny MAX_OUTSTANDING.
    underflow  = active && (32'(credit) > 32'(avail));
    over_issue = active && wr_req_valid &&
                 ((state_reg == S_DRAIN) || (outstanding_reg == OUT_MAX));
    // Idle timer only runs while lines are in flight and nothing comes back.
    tmo_inc    = (wr_rsp_valid || (outstanding_reg == '0)) ? '0 : tmo_reg + TW'(1);
    timeout    = active && (tmo_inc == TMO_LIMIT);

    state_next       = state_reg;
    outstanding_next = outstanding_reg;
    req_count_next   = req_count_reg;
    rsp_count_next   = rsp_count_reg;
    expected_next    = expected_reg;
    err_code_next    = err_code_reg;
    tmo_next         = tmo_reg;

    case (state_reg)
      S_RUN, S_DRAIN: begin
        // Lowest error code wins; the offending cycle's traffic is not counted.
        if (underflow) begin
          state_next       = S_ERROR;
          err_code_next    = 2'd1;
          outstanding_next = '0;
        end else if (over_issue) begin
          state_next    = S_ERROR;
          err_code_next = 2'd2;
        end else if (timeout) begin
          state_next    = S_ERROR;
          err_code_next = 2'd3;
        end else begin
          outstanding_next = out_upd[OW-1:0];
          if (wr_req_valid && (req_count_reg != '1))
            req_count_next = req_count_reg + CNT_W'(1);
          rsp_count_next = rsp_sum[CNT_W] ? '1 : rsp_sum[CNT_W-1:0];
          tmo_next       = tmo_inc;
          if ((state_reg == S_RUN) && (req_count_next == expected_reg))
            state_next = S_DRAIN;
          else if ((state_reg == S_DRAIN) && (out_upd == '0))
            state_next = S_DONE;
        end
      end
      default: begin
        // IDLE, DONE, ERROR (and any illegal encoding) accept start.
        if (start_ok) begin
          expected_next    = expected_lines;
          outstanding_next = '0;
          req_count_next   = '0;
          rsp_count_next   = '0;
          err_code_next    = 2'd0;
          tmo_next         = '0;
          state_next       = (expected_lines == '0) ? S_DONE : S_RUN;
        end else if ((state_reg != S_IDLE) && (state_reg != S_ERROR)) begin
          state_next = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= S_IDLE;
      outstanding_reg <= '0;
      req_count_reg   <= '0;
      rsp_count_reg   <= '0;
      expected_reg    <= '0;
      err_code_reg    <= 2'd0;
      tmo_reg         <= '0;
      issue_ok_reg    <= 1'b0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      error_reg       <= 1'b0;
    end else begin
      state_reg       <= state_next;
      outstanding_reg <= outstanding_next;
      req_count_reg   <= req_count_next;
      rsp_count_reg   <= rsp_count_next;
      expected_reg    <= expected_next;
      err_code_reg    <= err_code_next;
      tmo_reg         <= tmo_next;
      // Status flags are registered from the next-state values so they line up
      // with the counters they describe.
      issue_ok_reg    <= (state_next == S_RUN) && (outstanding_next < OUT_MAX);
      busy_reg        <= (state_next == S_RUN) || (state_next == S_DRAIN);
      done_reg        <= (state_next == S_DONE);
      error_reg       <= (state_next == S_ERROR);
    end
  end

`ifdef CCIP_WR_TRK_PERF_EN
  logic [31:0] run_cycles_reg;

  always_ff @(posedge clk) begin
    if (reset)
      run_cycles_reg <= '0;
    else if (start_ok)
      run_cycles_reg <= '0;
    else if (active && (run_cycles_reg != '1))
      run_cycles_reg <= run_cycles_reg + 32'd1;
  end

  assign run_cycles = run_cycles_reg;
`else
  assign run_cycles = '0;
`endif

  assign issue_ok    = issue_ok_reg;
  assign outstanding = outstanding_reg;
  assign req_count   = req_count_reg;
  assign rsp_count   = rsp_count_reg;
  assign busy        = busy_reg;
  assign done        = done_reg;
  assign error       = error_reg;
  assign err_code    = err_code_reg;

endmodule
